// File: rtl/line_scheduler.sv
// line_scheduler: measures the rotor period between opto frame pulses and
// spreads LINES evenly spaced line strobes over each revolution.
// Optional FIFO-underrun handling is enabled by defining LINE_SCHED_UNDERRUN_EN.
// Ports:
//   sys_clk, global_rst (sync, active-high)
//   frame_pulse, fifo_ready            : inputs
//   line_pulse, line_idx, frame_start  : line strobe outputs
//   period_o                           : last accepted period
//   running, stalled                   : scheduler state
//   line_skip, underrun_cnt            : starvation reporting
module line_scheduler #(
  parameter int LINES      = 360,
  parameter int CNT_W      = 24,
  parameter int LIDX_W     = 9,
  parameter int MIN_PERIOD = 4096
) (
  input  logic              sys_clk,
  input  logic              global_rst,
  input  logic              frame_pulse,
  input  logic              fifo_ready,
  output logic              line_pulse,
  output logic [LIDX_W-1:0] line_idx,
  output logic              frame_start,
  output logic [CNT_W-1:0]  period_o,
  output logic              running,
  output logic              stalled,
  output logic              line_skip,
  output logic [7:0]        underrun_cnt
);

  localparam int EW = LIDX_W + 1;
  localparam logic [EW-1:0]  LINES_E = EW'(LINES);
  localparam logic [CNT_W:0] LINES_C = (CNT_W+1)'(LINES);
  localparam logic [CNT_W:0] MIN_C   = (CNT_W+1)'(MIN_PERIOD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [EW-1:0]      emitted_q, emitted_d;
  logic [LIDX_W-1:0]  line_idx_q, line_idx_d;
  logic               line_pulse_q, line_pulse_d;
  logic               frame_start_q, frame_start_d;

  logic               cnt_sat;
  logic [CNT_W:0]     cnt_p1;
  logic [CNT_W-1:0]   period_new;
  logic               accept;
  logic               to_stall;
  logic               pulse_edge;
  logic               step;
  logic               due;
  logic [CNT_W:0]     acc_sum;
  logic [CNT_W-1:0]   acc_sub;

`ifdef LINE_SCHED_UNDERRUN_EN
  logic               line_skip_q, line_skip_d;
  logic [7:0]         underrun_q, underrun_d;
`else
  logic               unused_fifo_ready;
  assign unused_fifo_ready = fifo_ready;
`endif

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    acc_d         = acc_q;
    emitted_d     = emitted_q;
    line_idx_d    = line_idx_q;
    pulse_edge    = 1'b0;
    step          = 1'b0;
    due           = 1'b0;

    cnt_sat    = &frame_cnt_q;
    cnt_p1     = {1'b0, frame_cnt_q} + 1'b1;
    // A saturated counter means the period no longer fits; clamp it.
    period_new = cnt_sat ? '1 : cnt_p1[CNT_W-1:0];
    accept     = frame_pulse &&
                 ((state_q == IDLE) || (state_q == STALL) ||
                  (cnt_p1 >= MIN_C));
    to_stall   = cnt_sat || (cnt_p1 >= {period_q, 1'b0});

    if (accept)       frame_cnt_d = '0;
    else if (cnt_sat) frame_cnt_d = frame_cnt_q;
    else              frame_cnt_d = cnt_p1[CNT_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = MEAS;
      end
      MEAS: begin
        if (accept) begin
          state_d    = RUN;
          period_d   = period_new;
          pulse_edge = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          period_d   = period_new;
          pulse_edge = 1'b1;
        end else if (to_stall) begin
          state_d = STALL;
        end else begin
          step = 1'b1;
        end
      end
      STALL: begin
        if (accept) state_d = MEAS;
      end
      default: state_d = IDLE;
    endcase

    // Bresenham-style divider: acc carries the remainder so the
    // line spacing error never accumulates across a revolution.
    acc_sum = {1'b0, acc_q} + LINES_C;
    acc_sub = acc_sum[CNT_W-1:0] - period_q;

    if (pulse_edge) begin
      acc_d      = '0;
      emitted_d  = EW'(1);
      line_idx_d = '0;
      due        = 1'b1;
    end else if (step && (emitted_q < LINES_E)) begin
      if (acc_sum >= {1'b0, period_q}) begin
        acc_d      = acc_sub;
        emitted_d  = emitted_q + 1'b1;
        line_idx_d = line_idx_q + 1'b1;
        due        = 1'b1;
      end else begin
        acc_d = acc_sum[CNT_W-1:0];
      end
    end

`ifdef LINE_SCHED_UNDERRUN_EN
    line_pulse_d = due && fifo_ready;
    line_skip_d  = due && !fifo_ready;
    underrun_d   = underrun_q;
    if (line_skip_d && (underrun_q != 8'hFF))
      underrun_d = underrun_q + 1'b1;
`else
    line_pulse_d = due;
`endif
    frame_start_d = pulse_edge && line_pulse_d;
  end

  always_ff @(posedge sys_clk) begin
    if (global_rst) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      period_q      <= '0;
      acc_q         <= '0;
      emitted_q     <= '0;
      line_idx_q    <= '0;
      line_pulse_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      period_q      <= period_d;
      acc_q         <= acc_d;
      emitted_q     <= emitted_d;
      line_idx_q    <= line_idx_d;
      line_pulse_q  <= line_pulse_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LINE_SCHED_UNDERRUN_EN
  always_ff @(posedge sys_clk) begin
    if (global_rst) begin
      line_skip_q <= 1'b0;
      underrun_q  <= '0;
    end else begin
      line_skip_q <= line_skip_d;
      underrun_q  <= underrun_d;
    end
  end

  assign line_skip    = line_skip_q;
  assign underrun_cnt = underrun_q;
`else
  assign line_skip    = 1'b0;
  assign underrun_cnt = 8'd0;
`endif

  assign line_pulse  = line_pulse_q;
  assign frame_start = frame_start_q;
  assign line_idx    = line_idx_q;
  assign period_o    = period_q;
  assign running     = (state_q == RUN);
  assign stalled     = (state_q == STALL);

endmodule

// File: tb/tb_line_scheduler.sv
// Scoreboard bench for line_scheduler (LINES=4, MIN_PERIOD=500).
// Expected strobes are queued by the driver; a monitor pops and compares.
module tb_line_scheduler;

  localparam int LINES = 4;
  localparam int NONE  = 1 << 30;

  logic        sys_clk = 1'b0;
  logic        global_rst = 1'b1;
  logic        frame_pulse = 1'b0;
  logic        fifo_ready = 1'b1;
  logic        line_pulse;
  logic [1:0]  line_idx;
  logic        frame_start;
  logic [23:0] period_o;
  logic        running;
  logic        stalled;
  logic        line_skip;
  logic [7:0]  underrun_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int cyc;
    int idx;
    bit skip;
  } exp_t;

  exp_t sb[$];

  line_scheduler #(
    .LINES(LINES), .CNT_W(24), .LIDX_W(2), .MIN_PERIOD(500)
  ) dut (
    .sys_clk(sys_clk),
    .global_rst(global_rst),
    .frame_pulse(frame_pulse),
    .fifo_ready(fifo_ready),
    .line_pulse(line_pulse),
    .line_idx(line_idx),
    .frame_start(frame_start),
    .period_o(period_o),
    .running(running),
    .stalled(stalled),
    .line_skip(line_skip),
    .underrun_cnt(underrun_cnt)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               name, cyc, got, exp);
    end
  endtask

  // Return just after posedge number n.
  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Drive frame_pulse so that posedge e samples it.
  task automatic pulse_at(input int e);
    chk("sched_pulse_late", int'(cyc < e), 1);
    go_to(e - 1);
    frame_pulse = 1'b1;
    go_to(e);
    frame_pulse = 1'b0;
  endtask

  // Lines of a frame starting at edge e with period p; line j falls
  // ceil(j*p/LINES) edges later; lines at/after nxt are dropped.
  task automatic push_frame(input int e, input int p, input int nxt,
                            input int skip_idx);
    exp_t x;
    for (int j = 0; j < LINES; j++) begin
      x.cyc = e + (j * p + LINES - 1) / LINES;
      x.idx = j;
`ifdef LINE_SCHED_UNDERRUN_EN
      x.skip = (j == skip_idx);
`else
      x.skip = 1'b0;
`endif
      if (x.cyc < nxt) sb.push_back(x);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      chk("missed_strobe_cyc", cyc, e.cyc);
    end
    if (line_pulse || line_skip || frame_start) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe_cyc", cyc, -1);
      end else begin
        e = sb.pop_front();
        chk("strobe_cyc", cyc, e.cyc);
        chk("strobe_idx", int'(line_idx), e.idx);
        chk("strobe_pulse", int'(line_pulse), int'(!e.skip));
        chk("strobe_skip", int'(line_skip), int'(e.skip));
        chk("frame_start", int'(frame_start),
            int'(e.idx == 0 && !e.skip));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_line_pulse"}, int'(line_pulse), 0);
    chk({tag, "_line_idx"}, int'(line_idx), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_period"}, int'(period_o), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_stalled"}, int'(stalled), 0);
    chk({tag, "_line_skip"}, int'(line_skip), 0);
    chk({tag, "_underrun"}, int'(underrun_cnt), 0);
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog: simulation did not end, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c, x, d, e, f, g, h, i, r, j, k, l;
    int exp_ur;
    a = 100;  b = 1100; c = 2100; x = 2400; d = 3100;
    e = 3700; f = 4300; g = 5800; h = 6500; i = 7200;
    r = 7400; j = 7500; k = 8300; l = 9100;
`ifdef LINE_SCHED_UNDERRUN_EN
    exp_ur = 1;
`else
    exp_ur = 0;
`endif

    go_to(3);
    @(negedge sys_clk);
    chk_all_zero("reset");
    go_to(4);
    global_rst = 1'b0;

    pulse_at(a);
    @(negedge sys_clk);
    chk("meas_running", int'(running), 0);

    pulse_at(b);
    push_frame(b, 1000, c, -1);
    @(negedge sys_clk);
    chk("run_running", int'(running), 1);
    chk("run_period", int'(period_o), 1000);

    pulse_at(c);
    push_frame(c, 1000, d, -1);
    @(negedge sys_clk);
    chk("c_period", int'(period_o), 1000);

    pulse_at(x);
    @(negedge sys_clk);
    chk("glitch_running", int'(running), 1);
    chk("glitch_period", int'(period_o), 1000);

    pulse_at(d);
    push_frame(d, 1000, e, -1);

    pulse_at(e);
    push_frame(e, 600, f, 2);
    @(negedge sys_clk);
    chk("short_period", int'(period_o), 600);

    go_to(e + 299);
    fifo_ready = 1'b0;
    go_to(e + 300);
    fifo_ready = 1'b1;

    pulse_at(f);
    push_frame(f, 600, NONE, -1);
    @(negedge sys_clk);
    chk("underrun_cnt", int'(underrun_cnt), exp_ur);

    go_to(f + 1199);
    @(negedge sys_clk);
    chk("pre_stall", int'(stalled), 0);
    go_to(f + 1200);
    @(negedge sys_clk);
    chk("stalled", int'(stalled), 1);
    chk("stall_running", int'(running), 0);
    chk("stall_period", int'(period_o), 600);
    chk("stall_idx_hold", int'(line_idx), 3);

    pulse_at(g);
    @(negedge sys_clk);
    chk("remeas_stalled", int'(stalled), 0);
    chk("remeas_running", int'(running), 0);

    pulse_at(h);
    push_frame(h, 700, i, -1);
    @(negedge sys_clk);
    chk("h_period", int'(period_o), 700);
    chk("h_running", int'(running), 1);

    pulse_at(i);
    push_frame(i, 700, r, -1);

    go_to(r - 1);
    global_rst = 1'b1;
    go_to(r);
    global_rst = 1'b0;
    @(negedge sys_clk);
    chk_all_zero("midreset");

    pulse_at(j);
    @(negedge sys_clk);
    chk("j_running", int'(running), 0);

    pulse_at(k);
    push_frame(k, 800, l, -1);
    @(negedge sys_clk);
    chk("k_period", int'(period_o), 800);

    pulse_at(l);
    push_frame(l, 800, NONE, -1);

    go_to(l + 700);
    @(negedge sys_clk);
    chk("sb_leftover", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
